// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared helpers for the parametrised FIFO:
//   clog2p1(n) : bits needed to hold a count from 0 to n inclusive
//   is_pow2(n) : true when n is a power of two and at least 2
package fifo_pkg;

    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
// Simple dual-port DEPTH x WIDTH storage array.
// Ports:
//   clk, reset          : clock, async active-high reset (read register only)
//   i_wr_en/addr/data   : synchronous write port
//   i_rd_en/addr        : read request; data registered into o_rd_data
//   o_rd_data           : registered read data, holds when no read
module fifo_ram #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read samples the pre-write contents, so a read and write to the same
    // slot on a full FIFO returns the old (oldest) word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/param_fifo.sv
// param_fifo
// Synchronous FIFO with occupancy level, almost-full/almost-empty flags,
// sticky overflow/underflow errors and a registered read-valid strobe.
// Ports:
//   clk, reset            : clock, async active-high reset
//   wr_en, wr_data        : write request and data
//   rd_en                 : read request
//   rd_data, rd_valid     : registered read data and its one-cycle strobe
//   full, empty           : level == DEPTH / level == 0
//   almost_full/empty     : level >= AFULL_TH / level <= AEMPTY_TH
//   level                 : current occupancy
//   overflow, underflow   : sticky rejected-access errors
//   clr_err               : synchronous clear of the error bits
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 256,
    parameter int DEPTH     = 4,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        rd_en,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        rd_valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [clog2p1(DEPTH)-1:0]   level,
    output logic                        overflow,
    output logic                        underflow,
    input  logic                        clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = clog2p1(DEPTH);
    localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_LVL  = LW'(AFULL_TH);
    localparam logic [LW-1:0] AEMPTY_LVL = LW'(AEMPTY_TH);

    if (!is_pow2(DEPTH)) begin : g_chk_depth
        $error("param_fifo: DEPTH must be a power of two >= 2");
    end
    if (AFULL_TH > DEPTH) begin : g_chk_afull
        $error("param_fifo: AFULL_TH must not exceed DEPTH");
    end
    if (AEMPTY_TH >= DEPTH) begin : g_chk_aempty
        $error("param_fifo: AEMPTY_TH must be below DEPTH");
    end

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic          w_rd_acc;
    logic          w_wr_acc;
    logic [LW-1:0] w_level_nxt;

    // Accepts use the flags registered at the start of the cycle; a full
    // FIFO can still take a write when a read frees a slot in the same cycle.
    assign w_rd_acc = rd_en & ~empty;
    assign w_wr_acc = wr_en & (~full | w_rd_acc);

    always_comb begin
        w_level_nxt = level;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_nxt = level + LW'(1);
            2'b01:   w_level_nxt = level - LW'(1);
            default: w_level_nxt = level;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            level        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (AFULL_TH == 0);
            almost_empty <= 1'b1;
            rd_valid     <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            level        <= w_level_nxt;
            full         <= (w_level_nxt == FULL_LVL);
            empty        <= (w_level_nxt == '0);
            almost_full  <= (w_level_nxt >= AFULL_LVL);
            almost_empty <= (w_level_nxt <= AEMPTY_LVL);
            rd_valid     <= w_rd_acc;
            // A new rejection in the same cycle as clr_err keeps the bit set.
            overflow     <= (wr_en & ~w_wr_acc) | (overflow  & ~clr_err);
            underflow    <= (rd_en & ~w_rd_acc) | (underflow & ~clr_err);
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (rd_data)
    );

endmodule

// File: tb/tb_param_fifo.sv
module tb_param_fifo;

    localparam int WIDTH     = 256;
    localparam int DEPTH     = 4;
    localparam int AFULL_TH  = DEPTH - 1;
    localparam int AEMPTY_TH = 1;
    localparam int LW        = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: stored words, words expected on the read port,
    // and the expected sticky error / strobe state.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] exp_q[$];
    bit               m_ov = 0;
    bit               m_un = 0;
    bit               m_rv = 0;

    param_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_flags();
        int lvl;
        lvl = m_q.size();
        chk("level",        WIDTH'(level),        WIDTH'(lvl));
        chk("full",         WIDTH'(full),         WIDTH'(lvl == DEPTH));
        chk("empty",        WIDTH'(empty),        WIDTH'(lvl == 0));
        chk("almost_full",  WIDTH'(almost_full),  WIDTH'(lvl >= AFULL_TH));
        chk("almost_empty", WIDTH'(almost_empty), WIDTH'(lvl <= AEMPTY_TH));
        chk("overflow",     WIDTH'(overflow),     WIDTH'(m_ov));
        chk("underflow",    WIDTH'(underflow),    WIDTH'(m_un));
        chk("rd_valid",     WIDTH'(rd_valid),     WIDTH'(m_rv));
    endtask

    // One clock of stimulus: drive at negedge, advance the model, check after posedge.
    task automatic step(input bit wr, input logic [WIDTH-1:0] d, input bit rd, input bit clr);
        bit ra;
        bit wa;
        @(negedge clk);
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        clr_err = clr;
        ra = rd && (m_q.size() > 0);
        wa = wr && ((m_q.size() < DEPTH) || ra);
        if (ra) exp_q.push_back(m_q.pop_front());
        if (wa) m_q.push_back(d);
        m_ov = (wr && !wa) || (m_ov && !clr);
        m_un = (rd && !ra) || (m_un && !clr);
        m_rv = ra;
        @(posedge clk);
        #1;
        check_flags();
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [WIDTH-1:0] w;
        for (int i = 0; i < WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Monitor: every rd_valid strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_valid", WIDTH'(1), WIDTH'(0));
            end else begin
                chk("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(negedge clk);
        check_flags();
        chk("reset_rd_data", rd_data, '0);
        reset = 1'b0;

        // Fill to full, then an over-full write.
        for (int i = 0; i < 4; i++) step(1, WIDTH'(8'hA0 + i), 0, 0);
        step(1, WIDTH'(8'hA4), 0, 0);
        step(0, '0, 0, 0);
        // Simultaneous read and write while full.
        step(1, WIDTH'(8'hB0), 1, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Read+write on empty: read rejected, write accepted.
        step(1, WIDTH'(8'hC0), 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);

        // Streaming at level 2.
        step(1, WIDTH'(16'hD000), 0, 0);
        step(1, WIDTH'(16'hD001), 0, 0);
        for (int i = 0; i < 20; i++) step(1, WIDTH'(16'hD100 + i), 1, 0);
        for (int i = 0; i < 2; i++) step(0, '0, 1, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 55), rnd_word(), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 5));
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, '0, 1, 1);
        step(0, '0, 0, 0);

        // Reset mid-stream at level 3 with an error pending.
        step(0, '0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, WIDTH'(8'hE0 + i), 0, 0);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = WIDTH'(8'hEF);
        #2;
        reset = 1'b1;
        m_q.delete();
        exp_q.delete();
        m_ov = 0;
        m_un = 0;
        m_rv = 0;
        #1;
        check_flags();
        wr_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // First access after reset sees an empty FIFO; then clear the error.
        step(0, '0, 1, 0);
        step(1, WIDTH'(8'hF0), 0, 1);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        chk("drained", WIDTH'(exp_q.size()), WIDTH'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
